// File: rtl/amds_adc_uart_tx.sv
// AMDS ADC sample link transmitter: snapshots four 16-bit samples on start_tx and
// sends them as twelve 8N1 UART bytes (header 0x90|N, MSB, LSB per sample).
module amds_adc_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int GAP_BITS     = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_tx,
    input  logic [15:0] adc_din0,
    input  logic [15:0] adc_din1,
    input  logic [15:0] adc_din2,
    input  logic [15:0] adc_din3,
    output logic        dout,
    output logic        busy,
    output logic        tx_done,
    output logic [15:0] counter_frames_sent,
    output logic [15:0] counter_triggers_dropped
);

    localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]        GAP_LAST = (GAP_BITS > 0) ? 4'(GAP_BITS - 1) : 4'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_GAP
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] clk_cnt_q;
    logic [2:0]       bit_cnt_q;
    logic [3:0]       gap_cnt_q;
    logic [3:0]       byte_idx_q;
    logic [7:0]       shift_q;
    logic             dout_q;
    logic             busy_q;
    logic             tx_done_q;
    logic [15:0]      frames_q;
    logic [15:0]      dropped_q;

    logic [15:0] din_w  [4];
    logic [15:0] snap_w [4];
    logic        load;
    logic        cnt_last;
    logic        byte_end;
    logic [3:0]  nxt_idx;
    logic [7:0]  nxt_byte;

    assign din_w[0] = adc_din0;
    assign din_w[1] = adc_din1;
    assign din_w[2] = adc_din2;
    assign din_w[3] = adc_din3;

    assign load = start_tx && (state_q == S_IDLE);

    // Samples are frozen at acceptance so later input changes never reach the line.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_snap
            logic [15:0] sample_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sample_q <= 16'h0000;
                end else if (load) begin
                    sample_q <= din_w[gi];
                end
            end
            assign snap_w[gi] = sample_q;
        end
    endgenerate

    assign cnt_last = (clk_cnt_q == CNT_LAST);
    assign nxt_idx  = byte_idx_q + 4'd1;

    always_comb begin
        byte_end = 1'b0;
        if (cnt_last) begin
            if (state_q == S_STOP && GAP_BITS == 0) begin
                byte_end = 1'b1;
            end else if (state_q == S_GAP && gap_cnt_q == GAP_LAST) begin
                byte_end = 1'b1;
            end
        end
    end

    always_comb begin
        nxt_byte = 8'h90;
        case (nxt_idx)
            4'd1:    nxt_byte = snap_w[0][15:8];
            4'd2:    nxt_byte = snap_w[0][7:0];
            4'd3:    nxt_byte = 8'h91;
            4'd4:    nxt_byte = snap_w[1][15:8];
            4'd5:    nxt_byte = snap_w[1][7:0];
            4'd6:    nxt_byte = 8'h92;
            4'd7:    nxt_byte = snap_w[2][15:8];
            4'd8:    nxt_byte = snap_w[2][7:0];
            4'd9:    nxt_byte = 8'h93;
            4'd10:   nxt_byte = snap_w[3][15:8];
            4'd11:   nxt_byte = snap_w[3][7:0];
            default: nxt_byte = 8'h90;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            clk_cnt_q  <= '0;
            bit_cnt_q  <= 3'd0;
            gap_cnt_q  <= 4'd0;
            byte_idx_q <= 4'd0;
            shift_q    <= 8'h00;
            dout_q     <= 1'b1;
            busy_q     <= 1'b0;
            tx_done_q  <= 1'b0;
            frames_q   <= 16'h0000;
            dropped_q  <= 16'h0000;
        end else begin
            tx_done_q <= 1'b0;
            if (start_tx && busy_q) begin
                dropped_q <= dropped_q + 16'd1;
            end

            case (state_q)
                S_IDLE: begin
                    if (start_tx) begin
                        state_q    <= S_START;
                        busy_q     <= 1'b1;
                        dout_q     <= 1'b0;
                        clk_cnt_q  <= '0;
                        byte_idx_q <= 4'd0;
                        shift_q    <= 8'h90;
                    end
                end
                S_START: begin
                    if (cnt_last) begin
                        clk_cnt_q <= '0;
                        bit_cnt_q <= 3'd0;
                        dout_q    <= shift_q[0];
                        state_q   <= S_DATA;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt_last) begin
                        clk_cnt_q <= '0;
                        if (bit_cnt_q == 3'd7) begin
                            dout_q  <= 1'b1;
                            state_q <= S_STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            shift_q   <= shift_q >> 1;
                            dout_q    <= shift_q[1];
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (cnt_last) begin
                        clk_cnt_q <= '0;
                        gap_cnt_q <= 4'd0;
                        state_q   <= S_GAP;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
                S_GAP: begin
                    if (cnt_last) begin
                        clk_cnt_q <= '0;
                        gap_cnt_q <= gap_cnt_q + 4'd1;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    dout_q  <= 1'b1;
                end
            endcase

            // End of the last stop/gap bit: chain the next byte or close the frame.
            if (byte_end) begin
                if (byte_idx_q == 4'd11) begin
                    state_q   <= S_IDLE;
                    busy_q    <= 1'b0;
                    tx_done_q <= 1'b1;
                    frames_q  <= frames_q + 16'd1;
                end else begin
                    state_q    <= S_START;
                    dout_q     <= 1'b0;
                    byte_idx_q <= nxt_idx;
                    shift_q    <= nxt_byte;
                end
            end
        end
    end

    assign dout                     = dout_q;
    assign busy                     = busy_q;
    assign tx_done                  = tx_done_q;
    assign counter_frames_sent      = frames_q;
    assign counter_triggers_dropped = dropped_q;

endmodule

// File: tb/tb_amds_adc_uart_tx.sv
// Bench for amds_adc_uart_tx: two instances (CPB=4/GAP=0 and CPB=8/GAP=2) with a
// serial-line decoder per instance checked against a byte scoreboard.
module tb_amds_adc_uart_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  start_v;
    logic [15:0] din0, din1, din2, din3;
    logic [1:0]  dout_v, busy_v, done_v;
    logic [15:0] frames0, drop0, frames1, drop1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_p    = 0;

    typedef struct {
        logic [7:0] b;
        bit         last;
    } exp_t;
    exp_t sb0[$];
    exp_t sb1[$];

    typedef struct {
        logic [15:0] d0, d1, d2, d3;
        logic [15:0] exp_frames;
    } vec_t;

    always #5 clk = ~clk;

    amds_adc_uart_tx #(.CLKS_PER_BIT(4), .GAP_BITS(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start_tx(start_v[0]),
        .adc_din0(din0), .adc_din1(din1), .adc_din2(din2), .adc_din3(din3),
        .dout(dout_v[0]), .busy(busy_v[0]), .tx_done(done_v[0]),
        .counter_frames_sent(frames0), .counter_triggers_dropped(drop0)
    );

    amds_adc_uart_tx #(.CLKS_PER_BIT(8), .GAP_BITS(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .start_tx(start_v[1]),
        .adc_din0(din0), .adc_din1(din1), .adc_din2(din2), .adc_din3(din3),
        .dout(dout_v[1]), .busy(busy_v[1]), .tx_done(done_v[1]),
        .counter_frames_sent(frames1), .counter_triggers_dropped(drop1)
    );

    initial forever begin
        @(posedge clk);
        cyc_p++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end else begin
            $display("ok   %s = 0x%0h", nm, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input int w, input logic [15:0] a, b, c, d);
        logic [15:0] s [4];
        exp_t e;
        s[0] = a; s[1] = b; s[2] = c; s[3] = d;
        for (int n = 0; n < 4; n++) begin
            for (int p = 0; p < 3; p++) begin
                e.b    = (p == 0) ? (8'h90 | 8'(n)) : ((p == 1) ? s[n][15:8] : s[n][7:0]);
                e.last = (n == 3 && p == 2);
                if (w == 0) sb0.push_back(e);
                else        sb1.push_back(e);
            end
        end
    endtask

    // Called just after a rising edge; start_tx is sampled on the following edge.
    task automatic send(input int w, input logic [15:0] a, b, c, d, output int k);
        k = cyc_p;
        din0 = a; din1 = b; din2 = c; din3 = d;
        start_v[w] = 1'b1;
        push_frame(w, a, b, c, d);
        tick();
        start_v[w] = 1'b0;
        chk($sformatf("dut%0d busy after trigger", w), 32'(busy_v[w]), 32'd1);
        chk($sformatf("dut%0d start bit after trigger", w), 32'(dout_v[w]), 32'd0);
    endtask

    task automatic wait_done(input int w, input int k, input int f, input string nm);
        bit seen = 1'b0;
        while (!seen && (cyc_p - k) <= f + 20) begin
            tick();
            if (done_v[w]) seen = 1'b1;
        end
        chk($sformatf("dut%0d %s tx_done latency", w, nm), seen ? 32'(cyc_p - k) : 32'hFFFF_FFFF, 32'(f + 1));
        chk($sformatf("dut%0d %s busy at tx_done", w, nm), 32'(busy_v[w]), 32'd0);
    endtask

    // Line decoder: samples mid-bit on falling edges and checks spacing between start bits.
    task automatic mon(input int w);
        int cpb, gap, cnt, cyc, start_cyc, exp_next, j;
        bit active;
        logic [7:0] sh;
        logic line;
        exp_t e;
        cpb = (w == 0) ? 4 : 8;
        gap = (w == 0) ? 0 : 2;
        active = 1'b0; cyc = 0; exp_next = -1; cnt = 0; start_cyc = 0; sh = 8'h00;
        forever begin
            @(negedge clk);
            cyc++;
            line = dout_v[w];
            if (!rst_n) begin
                active = 1'b0;
                exp_next = -1;
                if (w == 0) sb0.delete();
                else        sb1.delete();
            end else if (!active) begin
                if (line == 1'b0) begin
                    active = 1'b1;
                    cnt = 0;
                    start_cyc = cyc;
                    if (exp_next >= 0)
                        chk($sformatf("dut%0d byte spacing", w), 32'(cyc), 32'(exp_next));
                    exp_next = -1;
                end
            end else begin
                cnt++;
                if (cnt % cpb == cpb / 2) begin
                    j = cnt / cpb;
                    if (j >= 1 && j <= 8) begin
                        sh[j-1] = line;
                    end else if (j == 9) begin
                        chk($sformatf("dut%0d stop bit", w), 32'(line), 32'd1);
                        if ((w == 0 && sb0.size() == 0) || (w == 1 && sb1.size() == 0)) begin
                            chk($sformatf("dut%0d byte 0x%0h with empty scoreboard", w, sh), 32'd1, 32'd0);
                        end else begin
                            e = (w == 0) ? sb0.pop_front() : sb1.pop_front();
                            chk($sformatf("dut%0d byte", w), 32'(sh), 32'(e.b));
                            if (!e.last) exp_next = start_cyc + (10 + gap) * cpb;
                        end
                        active = 1'b0;
                    end
                end
            end
        end
    endtask

    initial begin
        vec_t vecs [4];
        int k, k2;

        vecs[0] = '{16'h1234, 16'hABCD, 16'h0000, 16'hFFFF, 16'd1};
        vecs[1] = '{16'hA5A5, 16'h5A5A, 16'h8001, 16'h7FFE, 16'd2};
        vecs[2] = '{16'h0001, 16'h8000, 16'hFFFE, 16'h0100, 16'd3};
        vecs[3] = '{16'hC3C3, 16'h3C3C, 16'hF00F, 16'h0FF0, 16'd4};

        rst_n = 1'b0;
        start_v = 2'b00;
        din0 = 16'h0; din1 = 16'h0; din2 = 16'h0; din3 = 16'h0;
        fork
            mon(0);
            mon(1);
        join_none

        repeat (3) tick();
        chk("reset dout", 32'(dout_v), 32'h3);
        chk("reset busy", 32'(busy_v), 32'h0);
        chk("reset tx_done", 32'(done_v), 32'h0);
        chk("reset frames0", 32'(frames0), 32'h0);
        chk("reset dropped0", 32'(drop0), 32'h0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Table-driven frames; inputs are scrambled right after acceptance.
        for (int i = 0; i < 4; i++) begin
            send(0, vecs[i].d0, vecs[i].d1, vecs[i].d2, vecs[i].d3, k);
            din0 = ~vecs[i].d0; din1 = ~vecs[i].d1; din2 = ~vecs[i].d2; din3 = ~vecs[i].d3;
            wait_done(0, k, 480, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d frames_sent", i), 32'(frames0), 32'(vecs[i].exp_frames));
            chk($sformatf("vec%0d scoreboard drained", i), 32'(sb0.size()), 32'd0);
            repeat (3) tick();
        end

        // Sample change one cycle after trigger.
        send(0, 16'h1234, 16'hABCD, 16'h0000, 16'hFFFF, k);
        din0 = 16'h5555;
        wait_done(0, k, 480, "snapshot");
        chk("snapshot frames_sent", 32'(frames0), 32'd5);
        chk("snapshot scoreboard drained", 32'(sb0.size()), 32'd0);
        repeat (2) tick();

        // Triggers while busy are dropped.
        send(0, 16'h0F0F, 16'hF0F0, 16'h1357, 16'h2468, k);
        while (cyc_p < k + 100) tick();
        start_v[0] = 1'b1; tick(); start_v[0] = 1'b0;
        while (cyc_p < k + 300) tick();
        start_v[0] = 1'b1; tick(); start_v[0] = 1'b0;
        wait_done(0, k, 480, "drop");
        chk("drop triggers_dropped", 32'(drop0), 32'd2);
        chk("drop frames_sent", 32'(frames0), 32'd6);
        chk("drop scoreboard drained", 32'(sb0.size()), 32'd0);
        repeat (2) tick();

        // Back-to-back: trigger in the tx_done cycle.
        send(0, 16'h1111, 16'h2222, 16'h3333, 16'h4444, k);
        wait_done(0, k, 480, "b2b first");
        send(0, 16'h9876, 16'h5432, 16'h10FE, 16'hDCBA, k2);
        wait_done(0, k2, 480, "b2b second");
        chk("b2b frames_sent", 32'(frames0), 32'd8);
        chk("b2b triggers_dropped", 32'(drop0), 32'd2);
        chk("b2b scoreboard drained", 32'(sb0.size()), 32'd0);
        repeat (2) tick();

        // Inter-byte gap instance.
        send(1, 16'h1234, 16'hABCD, 16'h0000, 16'hFFFF, k);
        wait_done(1, k, 1152, "gap");
        chk("gap frames_sent", 32'(frames1), 32'd1);
        chk("gap triggers_dropped", 32'(drop1), 32'd0);
        chk("gap scoreboard drained", 32'(sb1.size()), 32'd0);
        repeat (2) tick();

        // Reset in the middle of byte 5.
        send(0, 16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D, k);
        while (cyc_p < k + 210) tick();
        rst_n = 1'b0;
        #1;
        chk("midreset dout", 32'(dout_v[0]), 32'd1);
        chk("midreset busy", 32'(busy_v[0]), 32'd0);
        chk("midreset frames_sent", 32'(frames0), 32'd0);
        chk("midreset triggers_dropped", 32'(drop0), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        send(0, 16'h0246, 16'h8ACE, 16'h1357, 16'h9BDF, k);
        wait_done(0, k, 480, "after reset");
        chk("after reset frames_sent", 32'(frames0), 32'd1);
        chk("after reset scoreboard drained", 32'(sb0.size()), 32'd0);
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
